// File: rtl/cram_arbiter_if.sv
// Bundle of the requester-side and RAM-controller-side signals of cram_arbiter.
// The slave modport is the arbiter's view.
// The master modport is the view of the surrounding requesters and the controller.
interface cram_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16
);
  // Requester side, two requesters packed as [id]
  logic [1:0]                 req;
  logic [1:0]                 we;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 ack;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       busy;

  // RAM controller side
  logic                       mem_req;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_ready;
  logic                       mem_done;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_ready, mem_done, mem_rdata,
    output ack, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_ready, mem_done, mem_rdata,
    input  ack, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cram_arbiter.sv
// Single-outstanding-transaction round-robin arbiter.
// Two requesters share one cellular-RAM controller port:
//   requester 0 is the ROM/DIP loader, requester 1 is the core fetch path.
// All outputs are registered.
// The DONE state keeps a requester's req from being re-sampled in its ack cycle.
module cram_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16
) (
  input logic           clk,
  input logic           reset_n,
  cram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  gnt_q;
  logic                  last_q;
  logic [1:0]            ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  busy_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  any_req;
  logic                  winner;

  // Pick the requester to grant.
  // On a tie the requester that did not win last time takes it.
  always_comb begin
    any_req = |bus.req;
    winner  = 1'b0;
    case (bus.req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      ack_q       <= 2'b00;
      rdata_q     <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q       <= winner;
            last_q      <= winner;
            mem_we_q    <= bus.we[winner];
            mem_addr_q  <= bus.addr[winner];
            mem_wdata_q <= bus.wdata[winner];
            mem_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          // A done seen before the command is accepted is not ours.
          // It is ignored.
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            if (bus.mem_done) begin
              rdata_q <= bus.mem_rdata;
              ack_q   <= gnt_q ? 2'b10 : 2'b01;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end else begin
            state_q <= ISSUE;
          end
        end
        WAIT: begin
          if (bus.mem_done) begin
            rdata_q <= bus.mem_rdata;
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed self-checking bench for cram_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cram_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  cram_arbiter_if #(.ADDR_WIDTH(22), .DATA_WIDTH(16)) bus ();

  cram_arbiter #(.ADDR_WIDTH(22), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n       = 1'b0;
    bus.req       = 2'b00;
    bus.we        = 2'b00;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%h exp=0", bus.ack); end
    checks++; if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 22'h000000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0000) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    @(negedge clk);
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    bus.req     = 2'b01;
    bus.we      = 2'b00;
    bus.addr[0] = 22'h000123;
    tick; // cycle 1
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL read_mem_req got=%b exp=1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 22'h000123) begin failures++; $display("FAIL read_mem_addr got=%h exp=000123", bus.mem_addr); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL read_busy got=%b exp=1", bus.busy); end
    bus.mem_ready = 1'b1;
    tick; // cycle 2
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL read_req_drop got=%b exp=0", bus.mem_req); end
    tick; // cycle 3
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL read_early_ack got=%h exp=0", bus.ack); end
    tick; // cycle 4
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick; // cycle 5
    checks++; if (bus.ack !== 2'b01) begin failures++; $display("FAIL read_ack got=%h exp=1", bus.ack); end
    checks++; if (bus.rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=beef", bus.rdata); end
    bus.mem_done = 1'b0;
    bus.req      = 2'b00;
    tick; // cycle 6
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL read_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL read_ack_end got=%h exp=0", bus.ack); end
  endtask

  task automatic test_zero_latency;
    bus.req     = 2'b01;
    bus.we      = 2'b00;
    bus.addr[0] = 22'h000456;
    tick; // cycle 1
    bus.mem_ready = 1'b1;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hC0DE;
    tick; // cycle 2: DONE directly, WAIT skipped
    checks++; if (bus.ack !== 2'b01) begin failures++; $display("FAIL zl_ack got=%h exp=1", bus.ack); end
    checks++; if (bus.rdata !== 16'hC0DE) begin failures++; $display("FAIL zl_rdata got=%h exp=c0de", bus.rdata); end
    bus.req       = 2'b00;
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b0;
    tick; // cycle 3
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zl_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_early_done;
    bus.req     = 2'b10;
    bus.we      = 2'b00;
    bus.addr[1] = 22'h0ABCDE;
    tick; // cycle 1
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick; // cycle 2
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL early_ack_c2 got=%h exp=0", bus.ack); end
    checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL early_mem_req got=%b exp=1", bus.mem_req); end
    bus.mem_done  = 1'b0;
    bus.mem_ready = 1'b1;
    tick; // cycle 3
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL early_ack_c3 got=%h exp=0", bus.ack); end
    bus.mem_ready = 1'b0;
    tick; // cycle 4
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL early_ack_c4 got=%h exp=0", bus.ack); end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h600D;
    tick; // cycle 5
    checks++; if (bus.ack !== 2'b10) begin failures++; $display("FAIL early_ack got=%h exp=2", bus.ack); end
    checks++; if (bus.rdata !== 16'h600D) begin failures++; $display("FAIL early_rdata got=%h exp=600d", bus.rdata); end
    bus.mem_done = 1'b0;
    bus.req      = 2'b00;
    tick;
  endtask

  task automatic test_backpressure;
    int n_ack;
    n_ack         = 0;
    bus.req       = 2'b10;
    bus.we        = 2'b10;
    bus.addr[1]   = 22'h3FFFFF;
    bus.wdata[1]  = 16'h5A5A;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (bus.ack !== 2'b00) n_ack++;
      checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL bp_mem_req[%0d] got=%b exp=1", i, bus.mem_req); end
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL bp_mem_we[%0d] got=%b exp=1", i, bus.mem_we); end
      checks++; if (bus.mem_addr !== 22'h3FFFFF) begin failures++; $display("FAIL bp_mem_addr[%0d] got=%h exp=3fffff", i, bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 16'h5A5A) begin failures++; $display("FAIL bp_mem_wdata[%0d] got=%h exp=5a5a", i, bus.mem_wdata); end
    end
    bus.mem_ready = 1'b1;
    tick;
    if (bus.ack !== 2'b00) n_ack++;
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      bus.mem_done = 1'b0;
      if (bus.ack !== 2'b00) begin
        n_ack++;
        checks++; if (bus.ack !== 2'b10) begin failures++; $display("FAIL bp_ack got=%h exp=2", bus.ack); end
        bus.req = 2'b00;
      end
    end
    checks++; if (n_ack !== 1) begin failures++; $display("FAIL bp_ack_count got=%0d exp=1", n_ack); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic exp_id;
    n             = 0;
    exp_id        = 1'b0;
    bus.we        = 2'b00;
    bus.addr[0]   = 22'h111111;
    bus.addr[1]   = 22'h222222;
    bus.mem_ready = 1'b1;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h7777;
    bus.req       = 2'b11;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      tick;
      if (bus.mem_req === 1'b1) begin
        checks++;
        if (bus.mem_addr !== (exp_id ? 22'h222222 : 22'h111111)) begin
          failures++; $display("FAIL rr_addr[%0d] got=%h exp_id=%0d", n, bus.mem_addr, exp_id);
        end
      end
      if (bus.ack !== 2'b00) begin
        checks++; if (bus.ack === 2'b11) begin failures++; $display("FAIL rr_both_ack got=%h", bus.ack); end
        checks++; if (bus.ack !== (exp_id ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_order[%0d] got=%h exp_id=%0d", n, bus.ack, exp_id); end
        exp_id = ~exp_id;
        n++;
        if (n == 8) bus.req = 2'b00;
      end
    end
    checks++; if (n !== 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", n); end
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    bus.req      = 2'b01;
    bus.we       = 2'b01;
    bus.addr[0]  = 22'h2AAAAA;
    bus.wdata[0] = 16'h1111;
    tick; // cycle 1
    bus.mem_ready = 1'b1;
    tick; // cycle 2: WAIT
    bus.mem_ready = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mw_busy_wait got=%b exp=1", bus.busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL mw_ack got=%h exp=0", bus.ack); end
    checks++; if (bus.rdata !== 16'h0000) begin failures++; $display("FAIL mw_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mw_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL mw_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL mw_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 22'h000000) begin failures++; $display("FAIL mw_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 16'h0000) begin failures++; $display("FAIL mw_mem_wdata got=%h exp=0", bus.mem_wdata); end
    bus.req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'h9999;
    tick;
    bus.mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL mw_late_ack[%0d] got=%h exp=0", i, bus.ack); end
      tick;
    end
    bus.we      = 2'b00;
    bus.addr[0] = 22'h0000AA;
    bus.addr[1] = 22'h0000BB;
    bus.req     = 2'b11;
    tick; // cycle 1
    checks++; if (bus.mem_addr !== 22'h0000AA) begin failures++; $display("FAIL mw_tie_addr got=%h exp=0000aa", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    bus.mem_done  = 1'b1;
    tick; // cycle 2
    checks++; if (bus.ack !== 2'b01) begin failures++; $display("FAIL mw_tie_ack got=%h exp=1", bus.ack); end
    bus.req       = 2'b00;
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b0;
    tick;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_read();
    test_zero_latency();
    test_early_done();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
